// File: rtl/multicycle_control_unit_if.sv
// Control bus between the multi-cycle sequencer and its instruction memory, data memory and datapath.
// The master modport is the control unit; the slave modport is the environment around it.
interface multicycle_control_unit_if #(
  parameter int OPCODE_W = 3,
  parameter int ALUOP_W  = 2,
  parameter int CNT_W    = 16
);
  logic [OPCODE_W-1:0] opcode;
  logic                fetch_ack;
  logic                mem_ack;
  logic                stall;

  logic                fetch_req;
  logic                ir_load;
  logic                reg_write;
  logic                alu_src;
  logic [ALUOP_W-1:0]  alu_op;
  logic                mem_read;
  logic                mem_write;
  logic                pc_en;
  logic                instr_done;
  logic                illegal;
  logic [2:0]          state;
  logic [CNT_W-1:0]    retired;

  modport master (
    input  opcode, fetch_ack, mem_ack, stall,
    output fetch_req, ir_load, reg_write, alu_src, alu_op, mem_read, mem_write,
           pc_en, instr_done, illegal, state, retired
  );

  modport slave (
    output opcode, fetch_ack, mem_ack, stall,
    input  fetch_req, ir_load, reg_write, alu_src, alu_op, mem_read, mem_write,
           pc_en, instr_done, illegal, state, retired
  );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multi-cycle instruction sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK with fetch and memory
// handshakes, execute stall, illegal-opcode trap or skip, and a retired-instruction counter.
module multicycle_control_unit #(
  parameter int OPCODE_W        = 3,
  parameter int ALUOP_W         = 2,
  parameter int CNT_W           = 16,
  parameter int TRAP_ON_ILLEGAL = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  multicycle_control_unit_if.master   bus
);

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_TRAP      = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] op_q;
  logic [CNT_W-1:0]    cnt_q;

  logic               c_fetch_req, c_ir_load, c_reg_write, c_alu_src;
  logic [ALUOP_W-1:0] c_alu_op;
  logic               c_mem_read, c_mem_write, c_pc_en, c_instr_done, c_illegal;

  logic       hi_bits;
  logic [2:0] base;
  logic       is_nop, is_sub, is_load, is_store, uses_imm, is_bad;

  // Opcodes wider than three bits are only legal when every extra bit is zero.
  if (OPCODE_W > 3) begin : g_wide
    assign hi_bits = |op_q[OPCODE_W-1:3];
  end else begin : g_narrow
    assign hi_bits = 1'b0;
  end

  assign base     = op_q[2:0];
  assign is_bad   = hi_bits || (base[2:1] == 2'b11);
  assign is_nop   = !hi_bits && (base == 3'd0);
  assign is_sub   = !hi_bits && (base == 3'd3);
  assign is_load  = !hi_bits && (base == 3'd4);
  assign is_store = !hi_bits && (base == 3'd5);
  assign uses_imm = !hi_bits && ((base == 3'd2) || is_load || is_store);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      op_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (c_ir_load)
        op_q <= bus.opcode;
      if (c_instr_done)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d      = state_q;
    c_fetch_req  = 1'b0;
    c_reg_write  = 1'b0;
    c_alu_src    = 1'b0;
    c_alu_op     = '0;
    c_mem_read   = 1'b0;
    c_mem_write  = 1'b0;
    c_pc_en      = 1'b0;
    c_instr_done = 1'b0;
    c_illegal    = 1'b0;
    case (state_q)
      S_FETCH: begin
        c_fetch_req = 1'b1;
        if (bus.fetch_ack)
          state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_nop) begin
          c_pc_en      = 1'b1;
          c_instr_done = 1'b1;
          state_d      = S_FETCH;
        end else if (is_bad) begin
          if (TRAP_ON_ILLEGAL != 0) begin
            state_d = S_TRAP;
          end else begin
            c_illegal = 1'b1;
            c_pc_en   = 1'b1;
            state_d   = S_FETCH;
          end
        end else begin
          state_d = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        c_alu_src   = uses_imm;
        c_alu_op[0] = is_sub;
        if (!bus.stall)
          state_d = (is_load || is_store) ? S_MEM : S_WRITEBACK;
      end
      // ALU controls stay up so the address computed in EXECUTE remains stable during the access.
      S_MEM: begin
        c_alu_src   = uses_imm;
        c_alu_op[0] = is_sub;
        c_mem_read  = is_load;
        c_mem_write = is_store;
        if (bus.mem_ack) begin
          if (is_load) begin
            state_d = S_WRITEBACK;
          end else begin
            c_pc_en      = 1'b1;
            c_instr_done = 1'b1;
            state_d      = S_FETCH;
          end
        end
      end
      S_WRITEBACK: begin
        c_reg_write  = 1'b1;
        c_pc_en      = 1'b1;
        c_instr_done = 1'b1;
        state_d      = S_FETCH;
      end
      S_TRAP: begin
        c_illegal = 1'b1;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  assign c_ir_load = c_fetch_req && bus.fetch_ack;

  // Outputs are forced low for the whole time reset is held, not just after the reset edge.
  assign bus.fetch_req  = c_fetch_req  && !reset;
  assign bus.ir_load    = c_ir_load    && !reset;
  assign bus.reg_write  = c_reg_write  && !reset;
  assign bus.alu_src    = c_alu_src    && !reset;
  assign bus.alu_op     = reset ? '0 : c_alu_op;
  assign bus.mem_read   = c_mem_read   && !reset;
  assign bus.mem_write  = c_mem_write  && !reset;
  assign bus.pc_en      = c_pc_en      && !reset;
  assign bus.instr_done = c_instr_done && !reset;
  assign bus.illegal    = c_illegal    && !reset;
  assign bus.state      = reset ? 3'd0 : state_q;
  assign bus.retired    = reset ? '0 : cnt_q;

endmodule
